// File: rtl/dma_engine.sv
// Burst DMA between external memory and the on-chip buffers: reads fill a buffer
// (or the layer descriptor), the output op drains the output buffer word by word.
module dma_engine #(
  parameter logic [31:0] INF_BASE = 32'h0000_0000,
  parameter logic [31:0] FMI_BASE = 32'h1000_0000,
  parameter logic [31:0] KEX_BASE = 32'h2000_0000,
  parameter logic [31:0] KPW_BASE = 32'h3000_0000,
  parameter logic [31:0] KDW_BASE = 32'h4000_0000,
  parameter logic [31:0] FMO_BASE = 32'h5000_0000,
  parameter logic [15:0] LEN_FMI  = 16'd64,
  parameter logic [15:0] LEN_KEX  = 16'd32,
  parameter logic [15:0] LEN_KPW  = 16'd16,
  parameter logic [15:0] LEN_KDW  = 16'd9,
  parameter logic [15:0] LEN_FMO  = 16'd16,
  parameter int          MAX_OUT  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_dma,
  input  logic [2:0]  dma_op,
  input  logic [31:0] dma_mem_info1,
  input  logic [31:0] dma_mem_info2,
  output logic        f_dma,
  output logic        busy,
  output logic        err_op,
  output logic [63:0] inf_conv,
  output logic        ext_req,
  output logic        ext_we,
  output logic [31:0] ext_addr,
  output logic [31:0] ext_wdata,
  input  logic        ext_gnt,
  input  logic        ext_rvalid,
  input  logic [31:0] ext_rdata,
  output logic        buf_we,
  output logic [2:0]  buf_sel,
  output logic [15:0] buf_addr,
  output logic [31:0] buf_wdata,
  output logic        obuf_re,
  output logic [15:0] obuf_addr,
  input  logic [31:0] obuf_rdata
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_WR_FETCH, S_WR_CAP, S_WR_ISSUE, S_DONE
  } state_t;

  localparam logic [15:0] MAX_OUT_W = 16'(MAX_OUT);

  state_t      state, state_n;
  logic [2:0]  op_q;
  logic [15:0] len_q;
  logic [31:0] base_q;
  logic [15:0] iss_cnt, rcv_cnt, wr_cnt;
  logic [31:0] wdata_q;
  logic [63:0] inf_q;

  logic [15:0] start_len;
  logic [31:0] region;
  logic [31:0] start_base;
  logic        start_bad;
  logic [15:0] len_m1;
  logic [15:0] outstanding;
  logic        rd_issue;
  logic        rd_beat;
  logic        op_bad_q;

  // command decode, evaluated on the live opcode so IDLE can latch in one edge
  always_comb begin
    start_len = 16'd0;
    region    = 32'h0;
    case (dma_op)
      3'd0: begin start_len = 16'd2;   region = INF_BASE; end
      3'd1: begin start_len = LEN_FMI; region = FMI_BASE; end
      3'd2: begin start_len = LEN_KEX; region = KEX_BASE; end
      3'd3: begin start_len = LEN_KPW; region = KPW_BASE; end
      3'd4: begin start_len = LEN_KDW; region = KDW_BASE; end
      3'd5: begin start_len = LEN_FMO; region = FMO_BASE; end
      default: begin start_len = 16'd0; region = 32'h0; end
    endcase
  end

  assign start_base  = region + dma_mem_info1 + dma_mem_info2;
  assign start_bad   = (dma_op == 3'd6) || (dma_op == 3'd7);
  assign len_m1      = len_q - 16'd1;
  assign outstanding = iss_cnt - rcv_cnt;
  // a request may stay up while data returns: outstanding only shrinks without a grant
  assign rd_issue    = (iss_cnt < len_q) && (outstanding < MAX_OUT_W);
  assign rd_beat     = (state == S_RD) && ext_rvalid;
  assign op_bad_q    = op_q[2] & op_q[1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n   = state;
    ext_req   = 1'b0;
    ext_we    = 1'b0;
    ext_addr  = 32'h0;
    obuf_re   = 1'b0;
    obuf_addr = 16'h0;
    f_dma     = 1'b0;
    err_op    = 1'b0;
    case (state)
      S_IDLE: begin
        if (s_dma) begin
          if (start_bad || start_len == 16'd0) state_n = S_DONE;
          else if (dma_op == 3'd5)             state_n = S_WR_FETCH;
          else                                 state_n = S_RD;
        end
      end
      S_RD: begin
        ext_req  = rd_issue;
        ext_addr = base_q + {16'h0, iss_cnt};
        if (ext_rvalid && rcv_cnt == len_m1) state_n = S_DONE;
      end
      S_WR_FETCH: begin
        obuf_re   = 1'b1;
        obuf_addr = wr_cnt;
        state_n   = S_WR_CAP;
      end
      S_WR_CAP: state_n = S_WR_ISSUE;
      S_WR_ISSUE: begin
        ext_req  = 1'b1;
        ext_we   = 1'b1;
        ext_addr = base_q + {16'h0, wr_cnt};
        if (ext_gnt) state_n = (wr_cnt == len_m1) ? S_DONE : S_WR_FETCH;
      end
      S_DONE: begin
        f_dma   = 1'b1;
        err_op  = op_bad_q;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q    <= 3'd0;
      len_q   <= 16'd0;
      base_q  <= 32'h0;
      iss_cnt <= 16'd0;
      rcv_cnt <= 16'd0;
      wr_cnt  <= 16'd0;
      wdata_q <= 32'h0;
      inf_q   <= 64'h0;
    end else begin
      case (state)
        S_IDLE: begin
          if (s_dma) begin
            op_q    <= dma_op;
            len_q   <= start_len;
            base_q  <= start_base;
            iss_cnt <= 16'd0;
            rcv_cnt <= 16'd0;
            wr_cnt  <= 16'd0;
          end
        end
        S_RD: begin
          if (ext_req && ext_gnt) iss_cnt <= iss_cnt + 16'd1;
          if (ext_rvalid) begin
            rcv_cnt <= rcv_cnt + 16'd1;
            if (op_q == 3'd0) begin
              if (rcv_cnt == 16'd0)      inf_q[31:0]  <= ext_rdata;
              else if (rcv_cnt == 16'd1) inf_q[63:32] <= ext_rdata;
            end
          end
        end
        S_WR_CAP:   wdata_q <= obuf_rdata;
        S_WR_ISSUE: if (ext_gnt) wr_cnt <= wr_cnt + 16'd1;
        default: ;
      endcase
    end
  end

  // buffer write port is a straight pass-through of the returning beat
  always_comb begin
    buf_we    = 1'b0;
    buf_sel   = 3'd0;
    buf_addr  = 16'h0;
    buf_wdata = 32'h0;
    if (rd_beat && op_q != 3'd0) begin
      buf_we    = 1'b1;
      buf_sel   = op_q;
      buf_addr  = rcv_cnt;
      buf_wdata = ext_rdata;
    end
  end

  assign busy      = (state != S_IDLE);
  assign ext_wdata = wdata_q;
  assign inf_conv  = inf_q;

endmodule

// File: tb/tb_dma_engine.sv
// Directed bench for dma_engine: memory/obuf responder, negedge monitor, scenario checks.
module tb_dma_engine;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        s_dma = 1'b0, z_s_dma = 1'b0;
  logic [2:0]  dma_op = 3'd0;
  logic [31:0] info1 = 32'h0, info2 = 32'h0;
  logic        ext_gnt = 1'b0, ext_rvalid = 1'b0;
  logic [31:0] ext_rdata = 32'h0, obuf_rdata = 32'h0;

  logic        f_dma, busy, err_op, ext_req, ext_we, buf_we, obuf_re;
  logic [63:0] inf_conv;
  logic [31:0] ext_addr, ext_wdata, buf_wdata;
  logic [2:0]  buf_sel;
  logic [15:0] buf_addr, obuf_addr;

  logic        z_f_dma, z_busy, z_err_op, z_ext_req, z_ext_we, z_buf_we, z_obuf_re;
  logic [63:0] z_inf_conv;
  logic [31:0] z_ext_addr, z_ext_wdata, z_buf_wdata;
  logic [2:0]  z_buf_sel;
  logic [15:0] z_buf_addr, z_obuf_addr;

  dma_engine dut (
    .clk(clk), .rst(rst), .s_dma(s_dma), .dma_op(dma_op),
    .dma_mem_info1(info1), .dma_mem_info2(info2),
    .f_dma(f_dma), .busy(busy), .err_op(err_op), .inf_conv(inf_conv),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
    .buf_we(buf_we), .buf_sel(buf_sel), .buf_addr(buf_addr), .buf_wdata(buf_wdata),
    .obuf_re(obuf_re), .obuf_addr(obuf_addr), .obuf_rdata(obuf_rdata)
  );

  dma_engine #(.LEN_KDW(16'd0)) dut_z (
    .clk(clk), .rst(rst), .s_dma(z_s_dma), .dma_op(dma_op),
    .dma_mem_info1(info1), .dma_mem_info2(info2),
    .f_dma(z_f_dma), .busy(z_busy), .err_op(z_err_op), .inf_conv(z_inf_conv),
    .ext_req(z_ext_req), .ext_we(z_ext_we), .ext_addr(z_ext_addr), .ext_wdata(z_ext_wdata),
    .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
    .buf_we(z_buf_we), .buf_sel(z_buf_sel), .buf_addr(z_buf_addr), .buf_wdata(z_buf_wdata),
    .obuf_re(z_obuf_re), .obuf_addr(z_obuf_addr), .obuf_rdata(obuf_rdata)
  );

  int n_chk = 0, n_fail = 0;
  int cyc = 0, lat = 1, gnt_dly = 0, wcnt = 0;
  logic [31:0] obuf_mem [64];

  logic [31:0] rq_addr [$];
  int          rq_due  [$];
  logic [32:0] req_q   [$];   // {we, addr}
  logic [31:0] wd_q    [$];
  logic [50:0] bw_q    [$];   // {sel, addr, data}
  int f_cnt = 0, err_cnt = 0, req_seen = 0, outst = 0, max_outst = 0, stab_err = 0;
  int last_rv_cyc = 0, last_gnt_cyc = 0, f_cyc = 0;
  logic        hold_v = 1'b0, h_we = 1'b0, obuf_re_d = 1'b0;
  logic [31:0] h_addr = 32'h0, h_wdata = 32'h0;
  logic [15:0] obuf_addr_d = 16'h0;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (a == 32'h0) return 32'hDEAD_BEEF;
    if (a == 32'h1) return 32'h0000_0123;
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // monitor: samples a settled cycle, inputs change at posedge+1
  always @(negedge clk) begin
    if (rst) begin
      if (ext_req) req_seen++;
      if (ext_rvalid) begin outst--; last_rv_cyc = cyc; end
      if (ext_req && ext_gnt) begin
        req_q.push_back({ext_we, ext_addr});
        last_gnt_cyc = cyc;
        if (!ext_we) begin
          rq_addr.push_back(ext_addr);
          rq_due.push_back(cyc + lat);
          outst++;
          if (outst > max_outst) max_outst = outst;
        end else wd_q.push_back(ext_wdata);
      end
      if (hold_v && (ext_req !== 1'b1 || ext_addr !== h_addr || ext_we !== h_we ||
                     ext_wdata !== h_wdata)) stab_err++;
      hold_v  = ext_req && !ext_gnt;
      h_addr  = ext_addr;
      h_we    = ext_we;
      h_wdata = ext_wdata;
      if (buf_we) bw_q.push_back({buf_sel, buf_addr, buf_wdata});
      if (f_dma) begin f_cnt++; f_cyc = cyc; end
      if (err_op) err_cnt++;
      obuf_re_d   = obuf_re;
      obuf_addr_d = obuf_addr;
    end else begin
      hold_v    = 1'b0;
      obuf_re_d = 1'b0;
      outst     = 0;
    end
  end

  // responder: grant policy, in-order read returns, 1-cycle obuf read
  always @(posedge clk) begin
    #1;
    cyc++;
    if (!rst) begin
      rq_addr.delete();
      rq_due.delete();
      ext_gnt    = 1'b0;
      ext_rvalid = 1'b0;
      wcnt       = 0;
    end else begin
      if (ext_req) begin
        if (wcnt >= gnt_dly) begin ext_gnt = 1'b1; wcnt = 0; end
        else begin ext_gnt = 1'b0; wcnt++; end
      end else begin
        ext_gnt = 1'b0;
        wcnt    = 0;
      end
      if (rq_due.size() > 0 && rq_due[0] <= cyc) begin
        ext_rvalid = 1'b1;
        ext_rdata  = mem_rd(rq_addr[0]);
        void'(rq_addr.pop_front());
        void'(rq_due.pop_front());
      end else begin
        ext_rvalid = 1'b0;
        ext_rdata  = 32'h0BAD_0BAD;
      end
      obuf_rdata = obuf_re_d ? obuf_mem[obuf_addr_d[5:0]] : 32'hBAD0_BAD0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    req_q.delete(); wd_q.delete(); bw_q.delete();
    req_seen = 0; max_outst = 0; stab_err = 0; err_cnt = 0;
  endtask

  task automatic start(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    tick();
    dma_op = op; info1 = a; info2 = b; s_dma = 1'b1;
    tick();
    s_dma = 1'b0;
  endtask

  task automatic wait_done(input int f_before, input string tag);
    int n = 0;
    while (f_cnt == f_before && n < 3000) begin
      @(negedge clk); #1; n++;
    end
    chk({tag, "_done"}, 64'(n < 3000), 64'd1);
  endtask

  task automatic wait_bw(input int cnt);
    int n = 0;
    while (bw_q.size() < cnt && n < 2000) begin
      @(negedge clk); #1; n++;
    end
    chk("bw_wait", 64'(n < 2000), 64'd1);
  endtask

  initial begin
    int f0;
    for (int k = 0; k < 64; k++) obuf_mem[k] = 32'hC0DE_0000 | (k * 32'h0101);

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_f", 64'(f_dma), 64'd0);
    chk("rst_req", 64'(ext_req), 64'd0);
    chk("rst_inf", inf_conv, 64'd0);
    chk("rst_misc", {buf_we, obuf_re, err_op, ext_we, ext_addr}, 64'd0);
    chk("rst_wdata", 64'(ext_wdata), 64'd0);
    rst = 1'b1;

    // descriptor load
    clear_logs(); lat = 3; gnt_dly = 0; f0 = f_cnt;
    start(3'd0, 32'h0, 32'h0);
    wait_done(f0, "inf");
    chk("inf_val", inf_conv, 64'h0000_0123_DEAD_BEEF);
    chk("inf_nreq", 64'(req_q.size()), 64'd2);
    chk("inf_a0", 64'(req_q[0]), 64'h0_0000_0000);
    chk("inf_a1", 64'(req_q[1]), 64'h0_0000_0001);
    chk("inf_nbuf", 64'(bw_q.size()), 64'd0);
    chk("inf_flat", 64'(f_cyc - last_rv_cyc), 64'd1);
    tick();
    chk("inf_nf", 64'(f_cnt - f0), 64'd1);
    chk("inf_idle", 64'(busy), 64'd0);

    // KEX burst, long latency, outstanding limit
    clear_logs(); lat = 6; gnt_dly = 0; f0 = f_cnt;
    start(3'd2, 32'd5, 32'd3);
    wait_done(f0, "kex");
    chk("kex_nreq", 64'(req_q.size()), 64'd32);
    for (int k = 0; k < 32; k++)
      chk($sformatf("kex_addr%0d", k), 64'(req_q[k]), 64'(33'(32'h2000_0008 + k)));
    chk("kex_maxout", 64'(max_outst), 64'd4);
    chk("kex_nbuf", 64'(bw_q.size()), 64'd32);
    for (int k = 0; k < 32; k++)
      chk($sformatf("kex_buf%0d", k), 64'(bw_q[k]),
          64'({3'd2, 16'(k), mem_rd(32'h2000_0008 + k)}));
    chk("kex_inf_keep", inf_conv, 64'h0000_0123_DEAD_BEEF);
    tick();
    chk("kex_idle", 64'(busy), 64'd0);

    // FMO drain with grant withheld two cycles, base wraps
    clear_logs(); gnt_dly = 2; f0 = f_cnt;
    start(3'd5, 32'hFFFF_FFF0, 32'h0000_0020);
    wait_done(f0, "fmo");
    chk("fmo_nreq", 64'(req_q.size()), 64'd16);
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("fmo_addr%0d", k), 64'(req_q[k]), 64'({1'b1, 32'h5000_0010 + k}));
      chk($sformatf("fmo_data%0d", k), 64'(wd_q[k]), 64'(obuf_mem[k]));
    end
    chk("fmo_stable", 64'(stab_err), 64'd0);
    chk("fmo_flat", 64'(f_cyc - last_gnt_cyc), 64'd1);
    chk("fmo_nbuf", 64'(bw_q.size()), 64'd0);
    gnt_dly = 0;

    // illegal op: DONE in the very next cycle, no request
    clear_logs(); f0 = f_cnt;
    start(3'd7, 32'h0, 32'h0);
    chk("ill_f", 64'(f_dma), 64'd1);
    chk("ill_err", 64'(err_op), 64'd1);
    chk("ill_busy", 64'(busy), 64'd1);
    tick();
    chk("ill_f_off", {f_dma, err_op, busy}, 64'd0);
    chk("ill_noreq", 64'(req_seen), 64'd0);

    // zero-length KDW on the overridden instance
    tick();
    dma_op = 3'd4; z_s_dma = 1'b1;
    tick();
    z_s_dma = 1'b0;
    chk("z_f", 64'(z_f_dma), 64'd1);
    chk("z_err", 64'(z_err_op), 64'd0);
    chk("z_busy", 64'(z_busy), 64'd1);
    chk("z_req", 64'(z_ext_req), 64'd0);
    tick();
    chk("z_f_off", {z_f_dma, z_busy, z_ext_req}, 64'd0);
    chk("main_quiet", 64'(busy), 64'd0);

    // FMI with ignored restart, then abort by reset
    clear_logs(); lat = 2; f0 = f_cnt;
    start(3'd1, 32'h100, 32'h4);
    wait_bw(5);
    tick();
    dma_op = 3'd0; info1 = 32'h0; info2 = 32'h0; s_dma = 1'b1;
    tick();
    s_dma = 1'b0;
    wait_bw(10);
    chk("ab_busy", 64'(busy), 64'd1);
    chk("ab_inf_keep", inf_conv, 64'h0000_0123_DEAD_BEEF);
    for (int k = 0; k < 10; k++)
      chk($sformatf("ab_buf%0d", k), 64'(bw_q[k]),
          64'({3'd1, 16'(k), mem_rd(32'h1000_0104 + k)}));
    rst = 1'b0;
    #1;
    chk("ab_rst_ctl", {f_dma, busy, err_op, ext_req, ext_we, buf_we, obuf_re}, 64'd0);
    chk("ab_rst_inf", inf_conv, 64'd0);
    chk("ab_rst_bus", {ext_addr, ext_wdata}, 64'd0);
    repeat (3) tick();
    chk("ab_nof", 64'(f_cnt - f0), 64'd0);
    rst = 1'b1;

    clear_logs(); f0 = f_cnt;
    start(3'd1, 32'h0, 32'h0);
    wait_done(f0, "fmi");
    chk("fmi_nbuf", 64'(bw_q.size()), 64'd64);
    for (int k = 0; k < 64; k++)
      chk($sformatf("fmi_buf%0d", k), 64'(bw_q[k]),
          64'({3'd1, 16'(k), mem_rd(32'h1000_0000 + k)}));
    tick();
    chk("fmi_nf", 64'(f_cnt - f0), 64'd1);
    chk("fmi_err", 64'(err_cnt), 64'd0);
    chk("fmi_idle", 64'(busy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got=1 exp=0");
    $fatal(1, "timeout");
  end
endmodule
